truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_settle_timer.sv | 29 ++
 rtl/truth_table_sequencer.sv | 109 ++++++++++
 tb/tb_truth_table_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared constants for the truth-table sequencer: FSM encodings and default sizing.
package tt_pkg;

  localparam int DEFAULT_N_IN   = 2;
  localparam int DEFAULT_SETTLE = 1;

  // Settle counter width covers the legal SETTLE range of 1..15.
  localparam int SETTLE_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that holds each vector for SETTLE cycles and pulses expire on the last one.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= SETTLE_W'(SETTLE);
    end else if (enable && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  // Load happens on the cycle before the hold starts, so count==1 marks the final hold cycle.
  assign expire = enable && (count == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector of a small gate, samples its output and scores it against a truth table.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   result_bits
);

  localparam int V     = 1 << N_IN;
  localparam int ERR_W = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  logic [1:0]       state;
  logic [N_IN-1:0]  index;
  logic [V-1:0]     exp_latched;
  logic [ERR_W-1:0] err_next;
  logic             mismatch;
  logic             last_vec;
  logic             timer_load;
  logic             timer_expire;

  assign last_vec   = (index == LAST_IDX);
  assign mismatch   = (state == ST_SAMPLE) && (dut_out != exp_latched[index]);
  assign timer_load = ((state == ST_IDLE) && start) || ((state == ST_SAMPLE) && !last_vec);

  // Saturating guard keeps err_count from wrapping even though V vectors can never exceed it.
  assign err_next = (mismatch && (err_count != ERR_W'(V))) ? err_count + ERR_W'(1) : err_count;

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .enable(state == ST_APPLY),
    .expire(timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      index       <= '0;
      exp_latched <= '0;
      err_count   <= '0;
      first_fail  <= '0;
      result_bits <= '0;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_latched <= expected;
            err_count   <= '0;
            first_fail  <= '0;
            result_bits <= '0;
            pass        <= 1'b0;
            index       <= '0;
            state       <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (timer_expire) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          result_bits[index] <= dut_out;
          err_count          <= err_next;
          if (mismatch && (err_count == '0)) begin
            first_fail <= index;
          end
          // pass is resolved here so it is already valid while done is high.
          if (last_vec) begin
            pass  <= (err_next == '0);
            state <= ST_DONE;
          end else begin
            index <= index + N_IN'(1);
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          index <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == ST_APPLY) || (state == ST_SAMPLE);
  assign done   = (state == ST_DONE);
  assign dut_in = busy ? index : '0;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: drives sweeps against an inverter-on-x gate and scores each done against a reference model.
module tb_truth_table_sequencer;

  localparam int N_IN = 2;
  localparam int V    = 4;

  typedef struct {
    logic [2:0] err;
    logic [1:0] ff;
    logic       pass;
    logic [3:0] bits;
  } result_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sel3 = 1'b0;
  logic [V-1:0] expected = '0;

  logic [1:0] dut_in_a, dut_in_b, first_fail_a, first_fail_b;
  logic       dut_out_a, dut_out_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_count_a, err_count_b;
  logic [3:0] result_bits_a, result_bits_b;

  logic [1:0] obs_dut_in, obs_first_fail;
  logic       obs_busy, obs_done, obs_pass;
  logic [2:0] obs_err;
  logic [3:0] obs_bits;

  result_t sb_q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Gate under test: s = ~x, where x is the MSB of the applied vector.
  assign dut_out_a = ~dut_in_a[1];
  assign dut_out_b = ~dut_in_b[1];

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel3), .expected(expected),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_count_a), .first_fail(first_fail_a),
    .result_bits(result_bits_a)
  );

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel3), .expected(expected),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_count_b), .first_fail(first_fail_b),
    .result_bits(result_bits_b)
  );

  assign obs_dut_in     = sel3 ? dut_in_b      : dut_in_a;
  assign obs_busy       = sel3 ? busy_b        : busy_a;
  assign obs_done       = sel3 ? done_b        : done_a;
  assign obs_pass       = sel3 ? pass_b        : pass_a;
  assign obs_err        = sel3 ? err_count_b   : err_count_a;
  assign obs_first_fail = sel3 ? first_fail_b  : first_fail_a;
  assign obs_bits       = sel3 ? result_bits_b : result_bits_a;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic result_t model_sweep(input logic [3:0] exp);
    result_t r;
    logic [1:0] vec;
    logic s;
    r = '{err: 3'd0, ff: 2'd0, pass: 1'b0, bits: 4'd0};
    for (int i = 0; i < V; i++) begin
      vec = 2'(i);
      s = ~vec[1];
      r.bits[i] = s;
      if (s !== exp[i]) begin
        if (r.err == 0) r.ff = vec;
        r.err = r.err + 3'd1;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // One sweep; optional extra start, mid-run change of expected, or mid-run reset (0 = unused).
  task automatic apply_stimulus(input logic use3, input logic [3:0] exp, input int extra_start_at,
                                input int change_at, input logic [3:0] new_exp, input int reset_at);
    int s;
    int total;
    int vec;
    result_t want;
    result_t got;
    s = use3 ? 3 : 1;
    total = V * (s + 1) + 1;
    want = model_sweep(exp);
    sel3 = use3;
    expected = exp;
    start = 1'b1;
    sb_q.push_back(want);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      start = (c == extra_start_at);
      if (c == change_at) expected = new_exp;
      if (c < total) begin
        vec = (c - 1) / (s + 1);
        check_output($sformatf("dut_in@%0d", c), 32'(obs_dut_in), 32'(vec));
        check_output($sformatf("busy@%0d", c), 32'(obs_busy), 32'd1);
        check_output($sformatf("done@%0d", c), 32'(obs_done), 32'd0);
      end else begin
        check_output("dut_in_at_done", 32'(obs_dut_in), 32'd0);
        check_output("busy_at_done", 32'(obs_busy), 32'd0);
        check_output("done_pulse", 32'(obs_done), 32'd1);
      end
      if (obs_done) begin
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check_output("err_count", 32'(obs_err), 32'(got.err));
          if (got.err != 0) check_output("first_fail", 32'(obs_first_fail), 32'(got.ff));
          check_output("pass", 32'(obs_pass), 32'(got.pass));
          check_output("result_bits", 32'(obs_bits), 32'(got.bits));
        end else begin
          check_output("spurious_done", 32'd1, 32'd0);
        end
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 32'(obs_busy), 32'd0);
        check_output("rst_dut_in", 32'(obs_dut_in), 32'd0);
        check_output("rst_err_count", 32'(obs_err), 32'd0);
        check_output("rst_bits", 32'(obs_bits), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < total; k++) begin
          @(negedge clk);
          check_output("no_done_after_abort", 32'(obs_done | obs_busy), 32'd0);
        end
        return;
      end
    end
    check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);
    check_output("pass_held", 32'(obs_pass), 32'(want.pass));
    check_output("done_one_cycle", 32'(obs_done), 32'd0);
  endtask

  initial begin
    $display("[TB] truth_table_sequencer bench starting");
    repeat (2) @(negedge clk);
    check_output("reset_dut_in", 32'({dut_in_a, dut_in_b}), 32'd0);
    check_output("reset_flags", 32'({busy_a, done_a, pass_a, busy_b, done_b, pass_b}), 32'd0);
    check_output("reset_err", 32'({err_count_a, err_count_b}), 32'd0);
    check_output("reset_ff_bits", 32'({first_fail_a, result_bits_a, first_fail_b, result_bits_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(1'b0, 4'b0011, 0, 0, 4'b0000, 0);
    apply_stimulus(1'b0, 4'b0110, 0, 0, 4'b0000, 0);
    apply_stimulus(1'b0, 4'b0011, 3, 0, 4'b0000, 0);
    apply_stimulus(1'b0, 4'b0011, 0, 0, 4'b0000, 4);
    apply_stimulus(1'b0, 4'b0011, 0, 0, 4'b0000, 0);
    apply_stimulus(1'b0, 4'b0011, 0, 2, 4'b1111, 0);
    apply_stimulus(1'b1, 4'b0011, 0, 0, 4'b0000, 0);
    apply_stimulus(1'b1, 4'b1100, 0, 0, 4'b0000, 0);
    for (int n = 0; n < 6; n++) begin
      apply_stimulus(1'b0, 4'($urandom_range(0, 15)), 0, 0, 4'b0000, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
